// File: rtl/div_stream_arbiter.sv
// div_stream_arbiter
// Round-robin arbiter that lends one serial mod-DIVISOR remainder engine to
// NUM_CH bit-serial requesters. A grant covers one whole frame (MSB first,
// closed by a last flag) plus its result handshake. The result reports the
// channel, the final remainder, divisibility and the saturating frame length.
// Storage does not grow with frame length: only the running remainder and a
// LEN_W-bit length counter are kept.

module div_stream_arbiter #(
    parameter int NUM_CH  = 4,
    parameter int DIVISOR = 3,
    parameter int LEN_W   = 16,
    localparam int REM_W  = $clog2(DIVISOR),
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] req_i,
    input  logic [NUM_CH-1:0] bit_valid_i,
    input  logic [NUM_CH-1:0] bit_i,
    input  logic [NUM_CH-1:0] bit_last_i,
    output logic [NUM_CH-1:0] bit_ready_o,
    output logic [NUM_CH-1:0] grant_o,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [CH_W-1:0]   res_ch_o,
    output logic              res_div_o,
    output logic [REM_W-1:0]  res_rem_o,
    output logic [LEN_W-1:0]  res_len_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    localparam logic [CH_W-1:0]   LAST_CH = CH_W'(NUM_CH - 1);
    localparam logic [LEN_W-1:0]  LEN_MAX = {LEN_W{1'b1}};
    localparam logic [CH_W:0]     NUM_CH_EXT = (CH_W + 1)'(NUM_CH);

    // One remainder step: shift the new bit in, then a single conditional
    // subtract. 2*rem+bit never exceeds 2*DIVISOR-1, so one subtract is enough.
    function automatic logic [REM_W-1:0] rem_step(input logic [REM_W-1:0] rem,
                                                  input logic             b);
        logic [REM_W:0] t;
        t = {rem, b};
        if (t >= (REM_W + 1)'(DIVISOR)) begin
            rem_step = REM_W'(t - (REM_W + 1)'(DIVISOR));
        end else begin
            rem_step = t[REM_W-1:0];
        end
    endfunction

    // State and registered outputs
    state_t             state_q;
    logic [NUM_CH-1:0]  grant_q;
    logic [NUM_CH-1:0]  ready_q;
    logic [CH_W-1:0]    gidx_q;
    logic [CH_W-1:0]    rr_ptr_q;
    logic [REM_W-1:0]   rem_q;
    logic [LEN_W-1:0]   len_q;
    logic               res_valid_q;
    logic [CH_W-1:0]    res_ch_q;
    logic               res_div_q;
    logic [REM_W-1:0]   res_rem_q;
    logic [LEN_W-1:0]   res_len_q;

    // Combinational helpers
    logic               arb_found_s;
    logic [CH_W-1:0]    arb_idx_s;
    logic [CH_W:0]      arb_sum_s;
    logic [NUM_CH-1:0]  arb_onehot_s;
    logic               cur_valid_s;
    logic               cur_bit_s;
    logic               cur_last_s;
    logic               beat_acc_s;
    logic [REM_W-1:0]   rem_d;
    logic [LEN_W-1:0]   len_d;
    logic [CH_W-1:0]    rr_ptr_d;

    // Round-robin pick: first requester at or after the pointer, wrapping.
    always_comb begin
        arb_found_s = 1'b0;
        arb_idx_s   = '0;
        arb_sum_s   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            arb_sum_s = {1'b0, rr_ptr_q} + (CH_W + 1)'(i);
            if (arb_sum_s >= NUM_CH_EXT) begin
                arb_sum_s = arb_sum_s - NUM_CH_EXT;
            end else begin
                arb_sum_s = arb_sum_s;
            end
            if (!arb_found_s && req_i[arb_sum_s[CH_W-1:0]]) begin
                arb_found_s = 1'b1;
                arb_idx_s   = arb_sum_s[CH_W-1:0];
            end else begin
                arb_found_s = arb_found_s;
            end
        end
        arb_onehot_s = {{(NUM_CH - 1){1'b0}}, 1'b1} << arb_idx_s;
    end

    // Granted-channel beat decode and next remainder / length / pointer.
    always_comb begin
        cur_valid_s = bit_valid_i[gidx_q];
        cur_bit_s   = bit_i[gidx_q];
        cur_last_s  = bit_last_i[gidx_q];
        beat_acc_s  = (state_q == ST_STREAM) && cur_valid_s && ready_q[gidx_q];
        rem_d       = rem_step(rem_q, cur_bit_s);
        if (len_q == LEN_MAX) begin
            len_d = len_q;
        end else begin
            len_d = len_q + LEN_W'(1'b1);
        end
        if (gidx_q == LAST_CH) begin
            rr_ptr_d = '0;
        end else begin
            rr_ptr_d = gidx_q + CH_W'(1'b1);
        end
    end

    // Arbitration / streaming / result FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            ready_q     <= '0;
            gidx_q      <= '0;
            rr_ptr_q    <= '0;
            rem_q       <= '0;
            len_q       <= '0;
            res_valid_q <= 1'b0;
            res_ch_q    <= '0;
            res_div_q   <= 1'b0;
            res_rem_q   <= '0;
            res_len_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arb_found_s) begin
                        grant_q <= arb_onehot_s;
                        ready_q <= arb_onehot_s;
                        gidx_q  <= arb_idx_s;
                        rem_q   <= '0;
                        len_q   <= '0;
                        state_q <= ST_STREAM;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_STREAM: begin
                    if (beat_acc_s) begin
                        rem_q <= rem_d;
                        len_q <= len_d;
                        if (cur_last_s) begin
                            ready_q     <= '0;
                            res_valid_q <= 1'b1;
                            res_ch_q    <= gidx_q;
                            res_rem_q   <= rem_d;
                            res_div_q   <= (rem_d == '0);
                            res_len_q   <= len_d;
                            state_q     <= ST_RESULT;
                        end else begin
                            state_q <= ST_STREAM;
                        end
                    end else begin
                        state_q <= ST_STREAM;
                    end
                end
                ST_RESULT: begin
                    // res_valid_q is always set here, so res_ready_i alone
                    // completes the handshake.
                    if (res_ready_i) begin
                        res_valid_q <= 1'b0;
                        grant_q     <= '0;
                        rr_ptr_q    <= rr_ptr_d;
                        state_q     <= ST_IDLE;
                    end else begin
                        state_q <= ST_RESULT;
                    end
                end
                default: begin
                    grant_q     <= '0;
                    ready_q     <= '0;
                    res_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bit_ready_o = ready_q;
    assign grant_o     = grant_q;
    assign res_valid_o = res_valid_q;
    assign res_ch_o    = res_ch_q;
    assign res_div_o   = res_div_q;
    assign res_rem_o   = res_rem_q;
    assign res_len_o   = res_len_q;

endmodule

// File: tb/tb_div_stream_arbiter.sv
// Bench for div_stream_arbiter: two instances share all inputs, one with the
// default parameters (DIVISOR=3, LEN_W=16) and one with DIVISOR=5, LEN_W=3.
// A table of frames from the test plan runs first, then hand sequences for
// reset, then random frames checked against a value-level reference model.

module tb_div_stream_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req_i;
    logic [3:0] bit_valid_i;
    logic [3:0] bit_i;
    logic [3:0] bit_last_i;
    logic       res_ready_i;

    logic [3:0]  g_ready, g_grant;
    logic        g_valid, g_div;
    logic [1:0]  g_ch, g_rem;
    logic [15:0] g_len;

    logic [3:0]  f_ready, f_grant;
    logic        f_valid, f_div;
    logic [1:0]  f_ch;
    logic [2:0]  f_rem;
    logic [2:0]  f_len;

    div_stream_arbiter #(.NUM_CH(4), .DIVISOR(3), .LEN_W(16)) dut (
        .clk(clk), .reset(reset), .req_i(req_i), .bit_valid_i(bit_valid_i),
        .bit_i(bit_i), .bit_last_i(bit_last_i), .bit_ready_o(g_ready),
        .grant_o(g_grant), .res_valid_o(g_valid), .res_ready_i(res_ready_i),
        .res_ch_o(g_ch), .res_div_o(g_div), .res_rem_o(g_rem), .res_len_o(g_len)
    );

    div_stream_arbiter #(.NUM_CH(4), .DIVISOR(5), .LEN_W(3)) dut5 (
        .clk(clk), .reset(reset), .req_i(req_i), .bit_valid_i(bit_valid_i),
        .bit_i(bit_i), .bit_last_i(bit_last_i), .bit_ready_o(f_ready),
        .grant_o(f_grant), .res_valid_o(f_valid), .res_ready_i(res_ready_i),
        .res_ch_o(f_ch), .res_div_o(f_div), .res_rem_o(f_rem), .res_len_o(f_len)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int rr_m   = 0;

    typedef struct {
        logic        do_reset;
        logic [3:0]  req;
        logic [63:0] bits;
        int          n;
        int          mode;
        int          rwait;
        int          ech;
        int          er3;
        int          er5;
        int          el16;
        int          el3;
    } vec_t;

    vec_t tbl[10];

    // Free-running clock.
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int i = 0; i < 4; i++) begin
            if (r[(p + i) % 4]) return (p + i) % 4;
        end
        return -1;
    endfunction

    task automatic chk_reset_state();
        chk("rst_grant", g_grant, 0);
        chk("rst_ready", g_ready, 0);
        chk("rst_valid", g_valid, 0);
        chk("rst_ch", g_ch, 0);
        chk("rst_div", g_div, 0);
        chk("rst_rem", g_rem, 0);
        chk("rst_len", g_len, 0);
        chk("rst5_grant", f_grant, 0);
        chk("rst5_valid", f_valid, 0);
        chk("rst5_len", f_len, 0);
    endtask

    task automatic chk_result(input string tag, input int ech, input int er3,
                              input int er5, input int el16, input int el3);
        chk({tag, "_valid"}, g_valid, 1);
        chk({tag, "_ch"}, g_ch, ech);
        chk({tag, "_rem3"}, g_rem, er3);
        chk({tag, "_div3"}, g_div, (er3 == 0) ? 1 : 0);
        chk({tag, "_len16"}, g_len, el16);
        chk({tag, "_grant"}, g_grant, longint'(1) << ech);
        chk({tag, "_ready"}, g_ready, 0);
        chk({tag, "5_valid"}, f_valid, 1);
        chk({tag, "5_ch"}, f_ch, ech);
        chk({tag, "5_rem5"}, f_rem, er5);
        chk({tag, "5_div5"}, f_div, (er5 == 0) ? 1 : 0);
        chk({tag, "5_len3"}, f_len, el3);
    endtask

    // One whole frame: grant, beats (with optional bubbles/noise), result hold,
    // handshake. DUT is expected to be idle on entry.
    task automatic do_frame(input logic [3:0] req, input logic [63:0] bits,
                            input int n, input int mode, input int rwait,
                            input int ech, input int er3, input int er5,
                            input int el16, input int el3);
        longint oh;
        oh = longint'(1) << ech;
        req_i = req;
        tick();
        chk("grant", g_grant, oh);
        chk("grant5", f_grant, oh);
        chk("no_res_early", g_valid, 0);
        for (int k = 0; k < n; k++) begin
            if ((mode == 1 && k > 0) || (mode == 2 && $urandom_range(0, 1) == 1)) begin
                bit_valid_i = (mode == 2) ? 4'($urandom) : 4'b0000;
                bit_i       = 4'($urandom);
                bit_last_i  = 4'($urandom);
                bit_valid_i[ech] = 1'b0;
                tick();
                chk("bubble_ready", g_ready, oh);
                chk("bubble_no_res", g_valid, 0);
            end
            chk("beat_ready", g_ready, oh);
            chk("beat_ready5", f_ready, oh);
            if (mode == 2) begin
                bit_valid_i = 4'($urandom);
                bit_i       = 4'($urandom);
                bit_last_i  = 4'($urandom);
            end else begin
                bit_valid_i = 4'b0000;
                bit_i       = 4'b0000;
                bit_last_i  = 4'b0000;
            end
            bit_valid_i[ech] = 1'b1;
            bit_i[ech]       = bits[n - 1 - k];
            bit_last_i[ech]  = (k == n - 1);
            tick();
        end
        bit_valid_i = 4'b0000;
        bit_i       = 4'b0000;
        bit_last_i  = 4'b0000;
        chk_result("res", ech, er3, er5, el16, el3);
        for (int w = 0; w < rwait; w++) begin
            tick();
            chk_result("hold", ech, er3, er5, el16, el3);
        end
        res_ready_i = 1'b1;
        tick();
        res_ready_i = 1'b0;
        chk("post_hs_valid", g_valid, 0);
        chk("post_hs_grant", g_grant, 0);
        chk("post_hs_grant5", f_grant, 0);
        rr_m = (ech + 1) % 4;
    endtask

    initial begin
        logic [63:0]     rbits;
        longint unsigned val;
        int              rn;
        int              rch;
        logic [3:0]      rreq;

        clk = 1'b0;
        reset = 1'b0;
        req_i = 4'b0000;
        bit_valid_i = 4'b0000;
        bit_i = 4'b0000;
        bit_last_i = 4'b0000;
        res_ready_i = 1'b0;

        //            rst   req      bits                     n  mode rw ch r3 r5 l16 l3
        tbl[0] = '{1'b1, 4'b0001, 64'b110,                 3,  0,  0, 0, 0, 1, 3,  3};
        tbl[1] = '{1'b1, 4'b1010, 64'b1011,                4,  0,  0, 1, 2, 1, 4,  4};
        tbl[2] = '{1'b0, 4'b1010, 64'b1001,                4,  0,  0, 3, 0, 4, 4,  4};
        tbl[3] = '{1'b0, 4'b1111, 64'b1,                   1,  0,  0, 0, 1, 1, 1,  1};
        tbl[4] = '{1'b0, 4'b1111, 64'b10,                  2,  0,  0, 1, 2, 2, 2,  2};
        tbl[5] = '{1'b0, 4'b1111, 64'b111,                 3,  0,  0, 2, 1, 2, 3,  3};
        tbl[6] = '{1'b0, 4'b1111, 64'b0000,                4,  0,  0, 3, 0, 0, 4,  4};
        tbl[7] = '{1'b0, 4'b0100, 64'b1111,                4,  1,  5, 2, 0, 0, 4,  4};
        tbl[8] = '{1'b0, 4'b0001, 64'b1111111111,          10, 0,  1, 0, 0, 3, 10, 7};
        tbl[9] = '{1'b0, 4'b0010, 64'b000,                 3,  0,  0, 1, 0, 0, 3,  3};

        for (int v = 0; v < 10; v++) begin
            if (tbl[v].do_reset) begin
                req_i = 4'b0000;
                reset = 1'b0;
                tick();
                chk_reset_state();
                reset = 1'b1;
                rr_m = 0;
            end
            do_frame(tbl[v].req, tbl[v].bits, tbl[v].n, tbl[v].mode, tbl[v].rwait,
                     tbl[v].ech, tbl[v].er3, tbl[v].er5, tbl[v].el16, tbl[v].el3);
        end

        // Reset in the middle of a ch0 frame after two bits.
        req_i = 4'b0001;
        tick();
        chk("mid_grant", g_grant, 4'b0001);
        for (int k = 0; k < 2; k++) begin
            bit_valid_i = 4'b0001;
            bit_i = 4'b0001;
            tick();
        end
        bit_valid_i = 4'b0000;
        bit_i = 4'b0000;
        reset = 1'b0;
        tick();
        chk_reset_state();
        reset = 1'b1;
        rr_m = 0;
        do_frame(4'b0001, 64'b10, 2, 0, 0, 0, 2, 2, 2, 2);

        // Reset while a result is pending discards it.
        req_i = 4'b0100;
        tick();
        chk("pend_grant", g_grant, 4'b0100);
        bit_valid_i = 4'b0100;
        bit_i = 4'b0100;
        bit_last_i = 4'b0100;
        tick();
        bit_valid_i = 4'b0000;
        bit_i = 4'b0000;
        bit_last_i = 4'b0000;
        chk("pend_valid", g_valid, 1);
        reset = 1'b0;
        tick();
        chk_reset_state();
        reset = 1'b1;
        rr_m = 0;

        // Random frames against the value-level model.
        for (int it = 0; it < 40; it++) begin
            rreq  = 4'($urandom_range(1, 15));
            rn    = $urandom_range(1, 40);
            rbits = {$urandom, $urandom};
            rbits = rbits & ((64'd1 << rn) - 64'd1);
            val   = rbits;
            rch   = pick(rreq, rr_m);
            do_frame(rreq, rbits, rn, 2, $urandom_range(0, 3), rch,
                     int'(val % 3), int'(val % 5), rn, (rn > 7) ? 7 : rn);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/div_stream_arbiter.md
Name: div_stream_arbiter

Overview:
Shares a single serial mod-DIVISOR remainder engine between NUM_CH requesting bit-streams. Each requester sends a frame: an unbounded-value binary number, MSB first, one bit per beat, terminated by a last flag. The block arbitrates round-robin and grants the engine for one whole frame. It then reports divisibility, final remainder and frame length through a result handshake. This replaces per-stream wide-register divisibility checkers, so resource use is independent of frame length.

Parameters:
NUM_CH, 4, number of requesting streams (>=2)
DIVISOR, 3, divisor for the remainder engine (>=2)
LEN_W, 16, width of the frame length counter
REM_W, $clog2(DIVISOR), derived; remainder width (not overridable)
CH_W, $clog2(NUM_CH), derived; channel index width

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
req_i  input  NUM_CH  per-channel request to stream a frame
bit_valid_i  input  NUM_CH  per-channel bit valid
bit_i  input  NUM_CH  per-channel data bit (MSB of number first)
bit_last_i  input  NUM_CH  marks the final bit of the frame
bit_ready_o  output  NUM_CH  per-channel bit accept; only the granted bit may be high
grant_o  output  NUM_CH  one-hot grant, held for the whole frame and result phase
res_valid_o  output  1  result valid
res_ready_i  input  1  result accept
res_ch_o  output  CH_W  channel index the result belongs to
res_div_o  output  1  1 when the frame value mod DIVISOR == 0
res_rem_o  output  REM_W  final remainder
res_len_o  output  LEN_W  number of bits accepted in the frame, saturating

Behaviour:
- Reset (reset==0 at a clk edge) forces:
  - state=IDLE
  - grant_o=0, bit_ready_o=0, res_valid_o=0
  - res_ch_o=0, res_div_o=0, res_rem_o=0, res_len_o=0
  - RR pointer=0, internal remainder=0, length=0
  - This applies from any state, including mid-frame or with a result pending. A pending result is discarded.
- FSM states: IDLE, STREAM, RESULT.
- IDLE:
  - If any req_i bit is set, select the first requesting channel at or after the RR pointer, wrapping modulo NUM_CH.
  - Register the one-hot grant, clear remainder and length, and go to STREAM. Grant is visible one cycle after req is sampled.
  - With no request, stay in IDLE.
- STREAM:
  - bit_ready_o[g]=1 for the granted channel g; all other bits are 0.
  - A beat is accepted when bit_valid_i[g] && bit_ready_o[g].
  - On accept: rem <= (2*rem + bit) mod DIVISOR, computed as t=2*rem+bit followed by one conditional subtract of DIVISOR (t <= 2*DIVISOR-1, so one subtract suffices). len <= len+1, saturating at 2^LEN_W-1.
  - Valid bubbles are allowed; no accept means no state change.
  - req_i, valid and last from non-granted channels are ignored. Deassertion of req_i[g] mid-frame is ignored; the frame ends only on an accepted beat with bit_last_i[g]=1.
  - On the accepted last beat: load res_* from the updated remainder and length, set res_valid_o=1 on the next cycle, and go to RESULT. Latency from last beat to result is 1 cycle.
- RESULT:
  - bit_ready_o=0; grant_o is held; res_* outputs are stable while res_valid_o && !res_ready_i.
  - On res_valid_o && res_ready_i: clear res_valid_o and grant_o, set RR pointer=(g+1) mod NUM_CH, go to IDLE.
  - Minimum gap between frames is therefore 1 IDLE cycle.
- Arithmetic:
  - A frame is at least 1 bit.
  - Leading zeros do not change the remainder.
  - A value of 0 gives res_div_o=1, res_rem_o=0.
  - res_div_o = (res_rem_o==0).
- Fairness: a continuously requesting channel waits at most NUM_CH-1 frames.

Test Plan:
- Single channel: ch0 sends bits 1,1,0 with last on the third bit (value 6) -> res_valid one cycle after the last beat; res_ch=0, res_div=1, res_rem=0, res_len=3.
- Contention: after reset, req_i=4'b1010 held, ch1 sends 1,0,1,1 (11) and ch3 sends 1,0,0,1 (9) -> ch1 is granted first with rem=2, div=0, len=4; ch3 is granted next with rem=0, div=1. Then with all four requesting, grant order is ch0, ch1, ch2, ch3.
- Bubbles and backpressure: ch2 sends 1,1,1,1 (15) with bit_valid low on alternate cycles, and res_ready held low for 5 cycles -> bit_ready_o is asserted only on ch2, the result is stable for 5 cycles with rem=0, div=1, len=4, and grant drops the cycle after the handshake.
- Reset mid-frame: reset asserted low for 1 cycle after 2 bits of a ch0 frame -> next cycle grant_o=0, res_valid_o=0; a fresh frame 1,0 (2) afterwards reports rem=2, len=2.
- Parameter variant DIVISOR=5, LEN_W=3: a 10-bit frame of value 1023 -> rem=3, div=0, res_len saturates at 7; a frame of bits 0,0,0 -> div=1, rem=0, len=3.
